// File: rtl/glitch_free_pkg.sv
// Shared types and helpers for the glitch-free clock divider.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package glitch_free_pkg;

  // Divider phase: stopped, or in the high / low half of a period.
  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // Working width of the clamp helper; callers cast to and from their own width.
  localparam int CLAMP_W = 32;

  // A divide-by-1 cannot be built from a registered toggle, so it runs as divide-by-2.
  function automatic logic [CLAMP_W-1:0] clamp_ratio(input logic [CLAMP_W-1:0] ratio);
    return (ratio == CLAMP_W'(1)) ? CLAMP_W'(2) : ratio;
  endfunction

endpackage

// File: rtl/glitch_free_div.sv
// Programmable clock divider whose ratio changes only at a period boundary.
// Latency: new ratio takes effect on the first high cycle after the boundary (STOP: 2 cycles after request).
// Backpressure: busy high while a request is pending; ratio_vld is ignored until it clears.
module glitch_free_div
  import glitch_free_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int RST_RATIO = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             ratio_vld,
  output logic             busy,
  output logic             ratio_ack,
  output logic [DIV_W-1:0] cur_ratio,
  output logic             clk_out,
  output logic             clk_en
);

  localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);
  localparam logic [DIV_W-1:0] RST_RATIO_V = DIV_W'(clamp_ratio(CLAMP_W'(RST_RATIO)));
  // Reset parks the FSM on the last low cycle so the first free cycle starts a high phase.
  localparam state_e           RST_STATE   = (RST_RATIO == 0) ? ST_STOP : ST_LOW;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_ratio_q, cur_ratio_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             clk_out_q, clk_out_d;
  logic             clk_en_q, clk_en_d;

  logic             boundary;
  logic             apply;
  logic [DIV_W-1:0] ratio_nxt;
  logic [DIV_W-1:0] req_clamped;

  // cnt holds remaining cycles of the phase minus one; high gets ceil(R/2), low floor(R/2).
  function automatic logic [DIV_W-1:0] high_load(input logic [DIV_W-1:0] r);
    return (r - ONE) >> 1;
  endfunction

  function automatic logic [DIV_W-1:0] low_load(input logic [DIV_W-1:0] r);
    return (r >> 1) - ONE;
  endfunction

  assign req_clamped = DIV_W'(clamp_ratio(CLAMP_W'(div_ratio)));
  assign boundary    = (state_q == ST_LOW) && (cnt_q == '0);
  assign apply       = busy_q && (boundary || (state_q == ST_STOP));
  assign ratio_nxt   = apply ? pend_q : cur_ratio_q;

  // Phase sequencing: a new ratio is only ever loaded when a high phase starts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_STOP: begin
        if (apply && (pend_q != '0)) begin
          state_d = ST_HIGH;
          cnt_d   = high_load(pend_q);
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_LOW;
          cnt_d   = low_load(cur_ratio_q);
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          if (ratio_nxt == '0) begin
            state_d = ST_STOP;
            cnt_d   = '0;
          end else begin
            state_d = ST_HIGH;
            cnt_d   = high_load(ratio_nxt);
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = ST_STOP;
        cnt_d   = '0;
      end
    endcase
  end

  // Request handshake and registered outputs, all derived from the next state.
  always_comb begin
    busy_d      = busy_q;
    pend_d      = pend_q;
    if (apply) begin
      busy_d = 1'b0;
    end else if (ratio_vld && !busy_q) begin
      busy_d = 1'b1;
      pend_d = req_clamped;
    end
    ack_d       = apply;
    cur_ratio_d = ratio_nxt;
    clk_out_d   = (state_d == ST_HIGH);
    clk_en_d    = (state_d == ST_HIGH) && (state_q != ST_HIGH);
  end

  // State register; reset truncates any phase in progress and drops a pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      cur_ratio_q <= RST_RATIO_V;
      pend_q      <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      clk_out_q   <= 1'b0;
      clk_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_ratio_q <= cur_ratio_d;
      pend_q      <= pend_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      clk_out_q   <= clk_out_d;
      clk_en_q    <= clk_en_d;
    end
  end

  assign busy      = busy_q;
  assign ratio_ack = ack_q;
  assign cur_ratio = cur_ratio_q;
  assign clk_out   = clk_out_q;
  assign clk_en    = clk_en_q;

endmodule
